// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline hazard controller for the 5-stage RISC-V core.
//               Detects load-use hazards (operand-use qualified, x0 excluded),
//               holds the front end for LOAD_LAT cycles per hazard via a
//               stall counter FSM, flushes IF/ID on taken branches and
//               honours an external whole-pipeline freeze.
//               Optional macro HAZARD_PERF_CNT_EN adds stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ext_freeze,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  stall_busy,
    output logic [PERF_W-1:0]     perf_stall_cycles,
    output logic [PERF_W-1:0]     perf_flushes
);

    localparam logic [0:0] c_idle     = 1'b0;
    localparam logic [0:0] c_stall    = 1'b1;
    // Cycles still owed after the detection cycle, which stalls by itself.
    localparam logic [2:0] c_cnt_load = 3'(LOAD_LAT - 1);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_hz;

    assign w_hz = ex_mem_read && (ex_rd != '0) &&
                  ((id_rs1_used && (ex_rd == id_rs1)) ||
                   (id_rs2_used && (ex_rd == id_rs2)));

    assign stall_busy = (r_state == c_stall) && !rst;

    // State and stall counter register; reset drops any stall in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Prioritised next-state and pipeline-control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (ext_freeze) begin
            // Everything holds; pending branch/hazard is re-evaluated later.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_state_nxt  = c_idle;
            w_cnt_nxt    = 3'd0;
        end else if (r_state == c_stall) begin
            // The load has left EX, so a fresh hazard match is irrelevant.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            w_cnt_nxt    = r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
                w_state_nxt = c_idle;
            end
        end else if (w_hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                w_state_nxt = c_stall;
                w_cnt_nxt   = c_cnt_load;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_W-1:0] c_perf_one = {{(PERF_W-1){1'b0}}, 1'b1};

    logic              w_stall_evt;
    logic              w_flush_evt;
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_flush;

    // Stall outputs are the only unfrozen, non-reset case with PC held and a bubble.
    assign w_stall_evt = !rst && !pc_write && id_ex_bubble;
    assign w_flush_evt = !rst && if_id_flush;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_evt) r_perf_stall <= r_perf_stall + c_perf_one;
            if (w_flush_evt) r_perf_flush <= r_perf_flush + c_perf_one;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flushes      = r_perf_flush;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed bench for hazard_stall_ctrl. Three instances with
//               LOAD_LAT = 1, 2, 3 share one stimulus stream; each cycle the
//               packed control outputs of all three are compared to
//               hand-computed vectors {pc_write, if_id_write, if_id_flush,
//               id_ex_bubble, stall_busy}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam logic [4:0] c_norm  = 5'b11000;
    localparam logic [4:0] c_stl   = 5'b00010;
    localparam logic [4:0] c_stlb  = 5'b00011;
    localparam logic [4:0] c_flsh  = 5'b11110;
    localparam logic [4:0] c_flshb = 5'b11111;
    localparam logic [4:0] c_frz   = 5'b00000;
    localparam logic [4:0] c_frzb  = 5'b00001;
    localparam logic [4:0] c_rst   = 5'b00010;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ext_freeze;

    logic [4:0]  w_out [1:3];
    logic [31:0] w_pst [1:3];
    logic [31:0] w_pfl [1:3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 1; g <= 3; g++) begin : g_dut
            logic pw, iw, fl, bb, sb;
            hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(g), .PERF_W(32)) u_dut (
                .clk              (clk),
                .rst              (rst),
                .id_rs1           (id_rs1),
                .id_rs2           (id_rs2),
                .id_rs1_used      (id_rs1_used),
                .id_rs2_used      (id_rs2_used),
                .ex_rd            (ex_rd),
                .ex_mem_read      (ex_mem_read),
                .ex_branch_taken  (ex_branch_taken),
                .ext_freeze       (ext_freeze),
                .pc_write         (pw),
                .if_id_write      (iw),
                .if_id_flush      (fl),
                .id_ex_bubble     (bb),
                .stall_busy       (sb),
                .perf_stall_cycles(w_pst[g]),
                .perf_flushes     (w_pfl[g])
            );
            assign w_out[g] = {pw, iw, fl, bb, sb};
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [4:0] e1, input logic [4:0] e2,
                       input logic [4:0] e3);
        @(negedge clk);
        chk({tag, "/lat1"}, 32'(w_out[1]), 32'(e1));
        chk({tag, "/lat2"}, 32'(w_out[2]), 32'(e2));
        chk({tag, "/lat3"}, 32'(w_out[3]), 32'(e3));
        @(posedge clk);
        #1;
    endtask

    task automatic set_hz(input logic on);
        ex_mem_read = on;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        id_rs1_used = 1'b1;
        id_rs2      = 5'd9;
        id_rs2_used = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ext_freeze = 1'b0;

        cyc("reset", c_rst, c_rst, c_rst);
        rst = 1'b0;
        cyc("idle", c_norm, c_norm, c_norm);

        // Load-use on rs1: LOAD_LAT cycles of stall each.
        set_hz(1'b1);
        cyc("hz_c1", c_stl, c_stl, c_stl);
        set_hz(1'b0);
        cyc("hz_c2", c_norm, c_stlb, c_stlb);
        cyc("hz_c3", c_norm, c_norm, c_stlb);
        cyc("hz_c4", c_norm, c_norm, c_norm);

        // x0 destination never stalls.
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        id_rs2 = 5'd0; id_rs2_used = 1'b0;
        cyc("x0", c_norm, c_norm, c_norm);
        // rs2 matches but is not read.
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b0;
        cyc("rs2_unused", c_norm, c_norm, c_norm);
        // Same match with rs2 read does stall.
        id_rs2_used = 1'b1;
        cyc("rs2_used", c_stl, c_stl, c_stl);
        ex_mem_read = 1'b0;
        cyc("rs2_d1", c_norm, c_stlb, c_stlb);
        cyc("rs2_d2", c_norm, c_norm, c_stlb);

        // Taken branch aborts a stall in progress.
        set_hz(1'b1);
        cyc("br_c1", c_stl, c_stl, c_stl);
        set_hz(1'b0); ex_branch_taken = 1'b1;
        cyc("br_c2", c_flsh, c_flshb, c_flshb);
        ex_branch_taken = 1'b0;
        cyc("br_c3", c_norm, c_norm, c_norm);

        // Freeze during a stall holds everything and does not consume stall cycles.
        set_hz(1'b1);
        cyc("fz_c1", c_stl, c_stl, c_stl);
        set_hz(1'b0); ext_freeze = 1'b1;
        for (int i = 0; i < 4; i++) cyc("fz_hold", c_frz, c_frzb, c_frzb);
        ext_freeze = 1'b0;
        cyc("fz_rel1", c_norm, c_stlb, c_stlb);
        cyc("fz_rel2", c_norm, c_norm, c_stlb);
        cyc("fz_rel3", c_norm, c_norm, c_norm);

        // Hazard presented under freeze is seen once the freeze drops.
        set_hz(1'b1); ext_freeze = 1'b1;
        cyc("fz_hz", c_frz, c_frz, c_frz);
        ext_freeze = 1'b0;
        cyc("fz_hz_rel", c_stl, c_stl, c_stl);

        // Reset mid-stall: immediate IDLE and counters cleared.
        set_hz(1'b0); rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pst", w_pst[3], 32'd0);
        chk("rst_mid_pfl", w_pfl[3], 32'd0);
        cyc("rst_mid", c_rst, c_rst, c_rst);
        rst = 1'b0;
        cyc("rst_after", c_norm, c_norm, c_norm);

        // Two hazards one cycle apart, then a branch.
        set_hz(1'b1);
        cyc("pf_c1", c_stl, c_stl, c_stl);
        set_hz(1'b0);
        cyc("pf_c2", c_norm, c_stlb, c_stlb);
        set_hz(1'b1);
        cyc("pf_c3", c_stl, c_stl, c_stlb);
        set_hz(1'b0);
        cyc("pf_c4", c_norm, c_stlb, c_norm);
        ex_branch_taken = 1'b1;
        cyc("pf_c5", c_flsh, c_flsh, c_flsh);
        ex_branch_taken = 1'b0;
        cyc("pf_c6", c_norm, c_norm, c_norm);
        chk("perf_st_l1", w_pst[1], c_perf ? 32'd2 : 32'd0);
        chk("perf_st_l2", w_pst[2], c_perf ? 32'd4 : 32'd0);
        chk("perf_st_l3", w_pst[3], c_perf ? 32'd3 : 32'd0);
        chk("perf_fl_l2", w_pfl[2], c_perf ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RISC-V core; next generation of the combinational load-use detector.
- Detects load-use hazards with operand-use qualification and x0 exclusion, and supports multi-cycle load latency through a stall counter FSM.
- Adds taken-branch flush and an external freeze input (e.g. data-memory wait).
- Sits between the ID/EX decode signals and the PC, IF/ID and ID/EX register-enable and bubble controls.

Parameters:
- REG_ADDR_W, 5: register index width.
- LOAD_LAT, 1: stall cycles required per load-use hazard; legal range 1..7.
- PERF_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-high.
- id_rs1  input  REG_ADDR_W  ID-stage source register 1.
- id_rs2  input  REG_ADDR_W  ID-stage source register 2.
- id_rs1_used  input  1  ID instruction reads rs1.
- id_rs2_used  input  1  ID instruction reads rs2.
- ex_rd  input  REG_ADDR_W  EX-stage destination register.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch or jump.
- ext_freeze  input  1  external whole-pipeline freeze request.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  clear IF/ID to NOP.
- id_ex_bubble  output  1  insert NOP into ID/EX.
- stall_busy  output  1  FSM is in STALL.
- perf_stall_cycles  output  PERF_W  load-use stall cycles (optional feature only).
- perf_flushes  output  PERF_W  flush events (optional feature only).

Behaviour:
- Hazard term: hz = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & ex_rd == id_rs1) | (id_rs2_used & ex_rd == id_rs2)).
- State register: IDLE or STALL, plus a 3-bit counter cnt. Both are reset asynchronously to IDLE and cnt = 0.
- Outputs are combinational from state and inputs, evaluated in this priority order:
  1. rst high: pc_write = 0, if_id_write = 0, if_id_flush = 0, id_ex_bubble = 1, stall_busy = 0.
  2. ext_freeze = 1: pc_write = 0, if_id_write = 0, if_id_flush = 0, id_ex_bubble = 0 (ID/EX holds). State and cnt hold. A branch or hazard presented during the freeze is evaluated again on the first unfrozen cycle.
  3. ex_branch_taken = 1: pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_bubble = 1. Next state is IDLE and cnt = 0; this aborts any STALL in progress.
  4. STALL: pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Each cycle cnt decrements; when cnt == 1, next state is IDLE.
  5. IDLE with hz = 1: same stall outputs in the detection cycle (zero latency). If LOAD_LAT > 1, next state is STALL with cnt = LOAD_LAT - 1; otherwise stay in IDLE.
  6. Otherwise: pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0.
- Total stall per load-use hazard is exactly LOAD_LAT cycles, not counting freeze cycles.
- hz is ignored while in STALL, because the load has already advanced past EX.
- stall_busy = 1 only in state STALL.
- If rst asserts mid-stall, the FSM returns to IDLE immediately and cnt = 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cycles increments on every unfrozen cycle with stall outputs active (cases 4 and 5).
  - perf_flushes increments on every unfrozen cycle of case 3.
  - Both counters wrap modulo 2^PERF_W and reset asynchronously to 0.
- Undefined: both perf outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- LOAD_LAT=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for that cycle only; stall_busy stays 0.
- LOAD_LAT=3: same hazard, then ex_mem_read=0 -> 3 consecutive stall cycles; stall_busy=1 during cycles 2-3, then normal outputs.
- ex_rd=0 with id_rs1=0 used, and separately ex_rd=7 with id_rs2=7 but id_rs2_used=0 -> no stall.
- LOAD_LAT=3: hazard, then ex_branch_taken=1 in cycle 2 -> if_id_flush=1, pc_write=1, state IDLE, no third stall cycle.
- LOAD_LAT=2: hazard, then ext_freeze=1 for 4 cycles in cycle 2 -> all enables 0 and id_ex_bubble=0 during the freeze; one remaining stall cycle after release.
- With HAZARD_PERF_CNT_EN and LOAD_LAT=2: two hazards plus one branch -> perf_stall_cycles=4, perf_flushes=1; rst asserted mid-stall -> counters 0, state IDLE.
